// File: rtl/line_delay_ctrl.sv
// One-line delay front end: drives BRAM port A read-before-write per accepted pixel and
// emits {current, above} vertical pairs through a two-stage valid/ready pipeline.
`timescale 1ns/1ps

module line_delay_ctrl #(
    parameter int WIDTH      = 8,
    parameter int INDEXWIDTH = 9,
    parameter int LINE_WIDTH = 512
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  in_sof,
    input  logic [WIDTH-1:0]      in_pix,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [WIDTH-1:0]      out_cur,
    output logic [WIDTH-1:0]      out_above,
    output logic                  out_first_row,
    output logic                  out_eol,
    output logic                  bram_ssr,
    output logic                  bram_en,
    output logic                  bram_we,
    output logic [INDEXWIDTH-1:0] bram_addr,
    output logic [WIDTH-1:0]      bram_din,
    input  logic [WIDTH-1:0]      bram_dout,
    input  logic                  bram_dack
);

    localparam logic [INDEXWIDTH-1:0] LAST_COL = INDEXWIDTH'(LINE_WIDTH - 1);
    localparam logic [INDEXWIDTH-1:0] COL_ONE  = {{(INDEXWIDTH-1){1'b0}}, 1'b1};

    logic                  run;
    logic [INDEXWIDTH-1:0] col;
    logic                  first_row;

    logic                  s1_valid;
    logic [WIDTH-1:0]      s1_pix;
    logic                  s1_first_row;
    logic                  s1_eol;

    logic                  s2_free;
    logic                  xfer;
    logic                  s1_to_s2;
    logic [INDEXWIDTH-1:0] pix_col;
    logic                  pix_first_row;
    logic                  pix_eol;

    // run keeps in_ready low through reset and for the edge on which rst_n is released
    assign s2_free  = !out_valid || out_ready;
    assign in_ready = run && (!s1_valid || s2_free);
    assign xfer     = in_valid && in_ready;
    assign s1_to_s2 = s1_valid && s2_free;

    assign bram_ssr  = 1'b0;
    assign bram_en   = xfer;
    assign bram_we   = xfer;
    assign bram_addr = pix_col;
    assign bram_din  = in_pix;

    // NOTE: every always_comb output gets a default first, so no path leaves it unassigned
    // and no latch is inferred.
    always_comb begin
        pix_col       = col;
        pix_first_row = first_row;
        if (in_sof) begin
            pix_col       = '0;
            pix_first_row = 1'b1;
        end
        pix_eol = (pix_col == LAST_COL);
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run       <= 1'b0;
            col       <= '0;
            first_row <= 1'b1;
        end else begin
            run <= 1'b1;
            if (xfer) begin
                col       <= pix_eol ? '0 : pix_col + COL_ONE;
                first_row <= pix_eol ? 1'b0 : pix_first_row;
            end
        end
    end

    // s1 tracks the BRAM access in flight; refill wins over drain in the same cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid     <= 1'b0;
            s1_pix       <= '0;
            s1_first_row <= 1'b0;
            s1_eol       <= 1'b0;
        end else if (xfer) begin
            s1_valid     <= 1'b1;
            s1_pix       <= in_pix;
            s1_first_row <= pix_first_row;
            s1_eol       <= pix_eol;
        end else if (s1_to_s2) begin
            s1_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid     <= 1'b0;
            out_cur       <= '0;
            out_above     <= '0;
            out_first_row <= 1'b0;
            out_eol       <= 1'b0;
        end else if (s1_to_s2) begin
            out_valid     <= 1'b1;
            out_cur       <= s1_pix;
            out_above     <= s1_first_row ? '0 : bram_dout;
            out_first_row <= s1_first_row;
            out_eol       <= s1_eol;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // BRAM must have acknowledged the access before its read data is consumed
    dack_check: assert property (@(posedge clk) disable iff (!rst_n) s1_to_s2 |-> bram_dack);

endmodule

// File: tb/tb_line_delay_ctrl.sv
// Directed and randomized bench for line_delay_ctrl: instance A (LINE_WIDTH=4) and B (LINE_WIDTH=5)
// share stimulus; a per-cycle monitor scores output pairs against a line-delay model.
`timescale 1ns/1ps

module tb_line_delay_ctrl;

    typedef struct {
        logic [17:0] pair;
        int          cyc;
    } log_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_sof = 1'b0;
    logic       out_ready = 1'b1;
    logic [7:0] in_pix = '0;
    logic       sel = 1'b0;

    logic       a_in_ready, a_out_valid, a_out_first_row, a_out_eol, a_ssr, a_en, a_we;
    logic [7:0] a_out_cur, a_out_above, a_din, a_dout;
    logic [8:0] a_addr;
    logic       a_dack = 1'b0;
    logic [7:0] a_mem [0:511];

    logic       b_in_ready, b_out_valid, b_out_first_row, b_out_eol, b_ssr, b_en, b_we;
    logic [7:0] b_out_cur, b_out_above, b_din, b_dout;
    logic [8:0] b_addr;
    logic       b_dack = 1'b0;
    logic [7:0] b_mem [0:511];

    logic       m_in_ready, m_out_valid, m_fr, m_eol, m_ssr, m_en, m_we;
    logic [7:0] m_cur, m_above, m_din;
    logic [8:0] m_addr;

    int          n_checks = 0;
    int          n_errors = 0;
    int          cyc = 0;
    int          en_count = 0;
    int          xfer_count = 0;
    int          pop_count = 0;
    int          blocked_count = 0;
    bit          last_xfer = 1'b0;
    bit          hold_prev = 1'b0;
    logic [18:0] prev_out = '0;
    bit          rand_ready = 1'b0;
    int          stall_left = 0;
    int          lw;
    logic [17:0] exp_q [$];
    log_t        out_log [$];
    int          m_col = 0;
    bit          m_first = 1'b1;
    logic [7:0]  m_mem [0:511];
    logic [17:0] obs_pair;
    logic [17:0] exp_pair;
    int          x0, e0, p0, b0;

    always #5 clk = ~clk;

    line_delay_ctrl #(.WIDTH(8), .INDEXWIDTH(9), .LINE_WIDTH(4)) dut_a (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(a_in_ready), .in_sof(in_sof),
        .in_pix(in_pix), .out_valid(a_out_valid), .out_ready(out_ready), .out_cur(a_out_cur),
        .out_above(a_out_above), .out_first_row(a_out_first_row), .out_eol(a_out_eol),
        .bram_ssr(a_ssr), .bram_en(a_en), .bram_we(a_we), .bram_addr(a_addr), .bram_din(a_din),
        .bram_dout(a_dout), .bram_dack(a_dack)
    );

    line_delay_ctrl #(.WIDTH(8), .INDEXWIDTH(9), .LINE_WIDTH(5)) dut_b (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(b_in_ready), .in_sof(in_sof),
        .in_pix(in_pix), .out_valid(b_out_valid), .out_ready(out_ready), .out_cur(b_out_cur),
        .out_above(b_out_above), .out_first_row(b_out_first_row), .out_eol(b_out_eol),
        .bram_ssr(b_ssr), .bram_en(b_en), .bram_we(b_we), .bram_addr(b_addr), .bram_din(b_din),
        .bram_dout(b_dout), .bram_dack(b_dack)
    );

    // Read-before-write port A models; contents survive reset like the real BRAM
    always @(posedge clk) begin
        if (a_en) begin
            a_dout         <= a_mem[a_addr];
            a_mem[a_addr]  <= a_din;
            a_dack         <= 1'b1;
        end
        if (b_en) begin
            b_dout         <= b_mem[b_addr];
            b_mem[b_addr]  <= b_din;
            b_dack         <= 1'b1;
        end
    end

    assign m_in_ready  = sel ? b_in_ready      : a_in_ready;
    assign m_out_valid = sel ? b_out_valid     : a_out_valid;
    assign m_fr        = sel ? b_out_first_row : a_out_first_row;
    assign m_eol       = sel ? b_out_eol       : a_out_eol;
    assign m_ssr       = sel ? b_ssr           : a_ssr;
    assign m_en        = sel ? b_en            : a_en;
    assign m_we        = sel ? b_we            : a_we;
    assign m_cur       = sel ? b_out_cur       : a_out_cur;
    assign m_above     = sel ? b_out_above     : a_out_above;
    assign m_din       = sel ? b_din           : a_din;
    assign m_addr      = sel ? b_addr          : a_addr;

    function automatic logic [17:0] pk(input int cur, input int above, input bit fr, input bit eol);
        return {8'(cur), 8'(above), fr, eol};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_col     = 0;
        m_first   = 1'b1;
        hold_prev = 1'b0;
        exp_q.delete();
    endtask

    task automatic model_push(input logic [7:0] pix, input bit sof);
        int c;
        bit fr;
        bit eol;
        c   = sof ? 0 : m_col;
        fr  = sof ? 1'b1 : m_first;
        eol = (c == lw - 1);
        exp_q.push_back(pk(int'(pix), fr ? 0 : int'(m_mem[c]), fr, eol));
        m_mem[c] = pix;
        m_col    = eol ? 0 : c + 1;
        m_first  = eol ? 1'b0 : fr;
    endtask

    // Called once per cycle on the falling edge, away from the active edge
    task automatic monitor();
        lw = sel ? 5 : 4;
        if (hold_prev)
            check("hold_stable", 32'({m_out_valid, m_cur, m_above, m_fr, m_eol}), 32'(prev_out));
        check("bram_we", 32'(m_we), 32'(m_en));
        check("bram_ssr", 32'(m_ssr), 32'(0));
        if (m_en) begin
            en_count++;
            check("addr_range", 32'(int'(m_addr) < lw), 32'(1));
            check("bram_din", 32'(m_din), 32'(in_pix));
        end
        last_xfer = in_valid && m_in_ready;
        if (in_valid && !m_in_ready)
            blocked_count++;
        if (last_xfer) begin
            xfer_count++;
            model_push(in_pix, in_sof);
        end
        if (m_out_valid && out_ready) begin
            obs_pair = {m_cur, m_above, m_fr, m_eol};
            if (exp_q.size() == 0) begin
                check("out_expected", 32'(exp_q.size()), 32'(1));
            end else begin
                exp_pair = exp_q.pop_front();
                check("pair", 32'(obs_pair), 32'(exp_pair));
            end
            out_log.push_back('{pair: obs_pair, cyc: cyc});
            pop_count++;
        end
        hold_prev = m_out_valid && !out_ready;
        prev_out  = {m_out_valid, m_cur, m_above, m_fr, m_eol};
    endtask

    task automatic tick();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
        cyc++;
        if (stall_left > 0) begin
            out_ready = 1'b0;
            stall_left--;
        end else if (rand_ready) begin
            out_ready = 1'($urandom_range(1));
        end else begin
            out_ready = 1'b1;
        end
    endtask

    task automatic send(input logic [7:0] pix, input bit sof);
        int k;
        in_valid = 1'b1;
        in_pix   = pix;
        in_sof   = sof;
        k = 0;
        do begin
            tick();
            k++;
        end while (!last_xfer && k < 100);
        check("send_accepted", 32'(last_xfer), 32'(1));
        in_valid = 1'b0;
        in_sof   = 1'b0;
    endtask

    task automatic drain();
        int k;
        k = 0;
        while ((exp_q.size() != 0 || m_out_valid) && k < 200) begin
            tick();
            k++;
        end
        check("drain_empty", 32'(exp_q.size()), 32'(0));
    endtask

    // Entered 1 ns after a rising edge; reset falls and rises mid-cycle
    task automatic pulse_reset();
        #2;
        in_valid = 1'b1;
        rst_n    = 1'b0;
        #1;
        check("rst_outputs",
              32'({m_in_ready, m_out_valid, m_cur, m_above, m_fr, m_eol, m_en}), 32'(0));
        model_reset();
        #9;
        rst_n = 1'b1;
        #1;
        check("rst_in_ready_low", 32'(m_in_ready), 32'(0));
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        check("rst_in_ready_rise", 32'(m_in_ready), 32'(1));
    endtask

    task automatic check_pair(input string tag, input int idx, input int cur, input int above,
                              input bit fr, input bit eol);
        if (idx < out_log.size())
            check(tag, 32'(out_log[idx].pair), 32'(pk(cur, above, fr, eol)));
        else
            check(tag, 32'(out_log.size()), 32'(idx + 1));
    endtask

    function automatic int cyc_at(input int idx);
        return (idx < out_log.size()) ? out_log[idx].cyc : -1;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        @(posedge clk);
        #1;
        pulse_reset();

        // Continuous 3-row frame, LINE_WIDTH=4
        out_log.delete();
        b0 = blocked_count;
        for (int i = 1; i <= 12; i++) send(8'(i), i == 1);
        drain();
        check("t1_count", 32'(out_log.size()), 32'(12));
        check_pair("t1_p0", 0, 1, 0, 1'b1, 1'b0);
        check_pair("t1_p3", 3, 4, 0, 1'b1, 1'b1);
        check_pair("t1_p4", 4, 5, 1, 1'b0, 1'b0);
        check_pair("t1_p7", 7, 8, 4, 1'b0, 1'b1);
        check_pair("t1_p11", 11, 12, 8, 1'b0, 1'b1);
        check("t1_rate", 32'(cyc_at(11) - cyc_at(0)), 32'(11));
        check("t1_no_block", 32'(blocked_count - b0), 32'(0));

        // Same stream with a 3-cycle downstream stall in row 1
        out_log.delete();
        b0 = blocked_count;
        for (int i = 1; i <= 12; i++) begin
            if (i == 7) stall_left = 3;
            send(8'(i), i == 1);
        end
        drain();
        check("t2_count", 32'(out_log.size()), 32'(12));
        check("t2_blocked", 32'(blocked_count - b0), 32'(3));
        check_pair("t2_p5", 5, 6, 2, 1'b0, 1'b0);
        check_pair("t2_p7", 7, 8, 4, 1'b0, 1'b1);
        check_pair("t2_p8", 8, 9, 5, 1'b0, 1'b0);
        check_pair("t2_p11", 11, 12, 8, 1'b0, 1'b1);

        // Mid-row sof on the third pixel of row 1
        out_log.delete();
        for (int i = 1; i <= 14; i++) send(8'(i), i == 1 || i == 7);
        drain();
        check("t3_count", 32'(out_log.size()), 32'(14));
        check_pair("t3_p6", 6, 7, 0, 1'b1, 1'b0);
        check_pair("t3_p9", 9, 10, 0, 1'b1, 1'b1);
        check_pair("t3_p10", 10, 11, 7, 1'b0, 1'b0);
        check_pair("t3_p13", 13, 14, 10, 1'b0, 1'b1);

        // Asynchronous reset during row 2
        for (int i = 1; i <= 9; i++) send(8'(i), i == 1);
        pulse_reset();
        out_log.delete();
        send(8'd10, 1'b0);
        send(8'd11, 1'b0);
        drain();
        check_pair("t4_p0", 0, 10, 0, 1'b1, 1'b0);
        check_pair("t4_p1", 1, 11, 0, 1'b1, 1'b0);

        // Single pixel then idle: latency and one BRAM access
        out_log.delete();
        e0 = en_count;
        send(8'h5a, 1'b0);
        check("t6_lat_t1", 32'(m_out_valid), 32'(0));
        tick();
        check("t6_lat_t2", 32'(m_out_valid), 32'(1));
        tick();
        check("t6_lat_t3", 32'(m_out_valid), 32'(0));
        for (int i = 0; i < 3; i++) tick();
        check("t6_en_once", 32'(en_count - e0), 32'(1));
        check_pair("t6_p0", 0, 8'h5a, 0, 1'b1, 1'b0);

        // Random valid/ready over 3 frames of 3 rows, LINE_WIDTH=5
        sel = 1'b1;
        pulse_reset();
        x0 = xfer_count;
        e0 = en_count;
        p0 = pop_count;
        rand_ready = 1'b1;
        for (int f = 0; f < 3; f++) begin
            for (int p = 0; p < 15; p++) begin
                while ($urandom_range(1) == 0) tick();
                send(8'($urandom_range(255)), p == 0);
            end
        end
        rand_ready = 1'b0;
        drain();
        check("t5_accepted", 32'(xfer_count - x0), 32'(45));
        check("t5_en_count", 32'(en_count - e0), 32'(xfer_count - x0));
        check("t5_pairs", 32'(pop_count - p0), 32'(45));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
